// File: rtl/product_accumulator.sv
// product_accumulator
//
// Sums COUNT consecutive unsigned 16-bit products into an ACC_W-bit accumulator
// and presents each completed sum as a registered result. Input and output both
// use valid/ready handshakes.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   clear       synchronous abort, drops the partial sum and any pending result
//   prod_valid  a product is presented on prod
//   prod_ready  a product is accepted this cycle (depends on state and rst_n only)
//   prod        unsigned product, zero-extended into the accumulator
//   res_valid   a completed sum is held on res
//   res_ready   downstream takes res this cycle
//   res         completed sum (registered)
//   res_ovf     sticky carry-out flag for the sum on res (registered)
//
// Configuration:
//   ACC_SATURATE_EN  when defined, a carry out of the accumulator clamps it to
//                    all ones for the rest of the group instead of wrapping.

module product_accumulator #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned COUNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [15:0]      prod,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res,
    output logic             res_ovf
);

    localparam int unsigned CntW = $clog2(COUNT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(COUNT - 1);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic             res_ovf_q, res_ovf_d;

    logic             accept;
    logic             last;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_add;

    // Datapath helpers
    assign accept = (state_q == StAccum) && prod_valid;
    assign last   = (cnt_q == CntLast);
    assign sum    = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod};
    assign carry  = sum[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped, any non-zero add carries again, so acc stays at all ones.
    assign acc_add = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (accept && last) state_d = StHold;
            StHold:  if (res_ready)      state_d = StAccum;
        endcase
        if (clear) begin
            state_d = StAccum;
        end
    end

    // Outputs
    always_comb begin
        prod_ready = rst_n && (state_q == StAccum);
        res_valid  = (state_q == StHold);
        res        = res_q;
        res_ovf    = res_ovf_q;
    end

    // Accumulator / result next-state
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        if (clear) begin
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            res_d     = '0;
            res_ovf_d = 1'b0;
        end else if (accept) begin
            if (last) begin
                // Final product: publish the sum and restart the group at zero.
                res_d     = acc_add;
                res_ovf_d = ovf_q | carry;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
            end else begin
                acc_d = acc_add;
                cnt_d = cnt_q + 1'b1;
                ovf_d = ovf_q | carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (24b/8, 16b/8, 24b/1) share one
// set of input drivers; each phase resets all and checks one instance against a
// group-level arithmetic model (total of the group's products, then wrap/clamp).

module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        prod_valid = 1'b0;
    logic [15:0] prod = '0;
    logic        res_ready = 1'b1;

    logic        a_rdy, a_rv, a_ovf;
    logic [23:0] a_res;
    logic        b_rdy, b_rv, b_ovf;
    logic [15:0] b_res;
    logic        c_rdy, c_rv, c_ovf;
    logic [23:0] c_res;

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_rdy, s_rv, s_ovf;
    logic [63:0] s_res;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(24), .COUNT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_ready(a_rdy), .prod(prod), .res_valid(a_rv), .res_ready(res_ready),
        .res(a_res), .res_ovf(a_ovf)
    );

    product_accumulator #(.ACC_W(16), .COUNT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_ready(b_rdy), .prod(prod), .res_valid(b_rv), .res_ready(res_ready),
        .res(b_res), .res_ovf(b_ovf)
    );

    product_accumulator #(.ACC_W(24), .COUNT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_ready(c_rdy), .prod(prod), .res_valid(c_rv), .res_ready(res_ready),
        .res(c_res), .res_ovf(c_ovf)
    );

    function automatic int width_of(input int sel);
        return (sel == 1) ? 16 : 24;
    endfunction

    function automatic int count_of(input int sel);
        return (sel == 2) ? 1 : 8;
    endfunction

    // Expected result of a whole group from its unbounded total.
    function automatic longint unsigned exp_res(input int sel, input longint unsigned tot);
        longint unsigned m;
        m = (64'd1 << width_of(sel)) - 64'd1;
        if (tot <= m) return tot;
`ifdef ACC_SATURATE_EN
        return m;
`else
        return tot & m;
`endif
    endfunction

    function automatic logic exp_ovf(input int sel, input longint unsigned tot);
        return tot > ((64'd1 << width_of(sel)) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        case (sel)
            0: begin s_rdy = a_rdy; s_rv = a_rv; s_ovf = a_ovf; s_res = 64'(a_res); end
            1: begin s_rdy = b_rdy; s_rv = b_rv; s_ovf = b_ovf; s_res = 64'(b_res); end
            default: begin s_rdy = c_rdy; s_rv = c_rv; s_ovf = c_ovf; s_res = 64'(c_res); end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int sel);
        rst_n = 1'b0;
        #1;
        sample(sel);
        chk("rst_low_ready", 64'(s_rdy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        sample(sel);
        chk("rst_ready", 64'(s_rdy), 64'd1);
        chk("rst_valid", 64'(s_rv), 64'd0);
        chk("rst_res", s_res, 64'd0);
        chk("rst_ovf", 64'(s_ovf), 64'd0);
    endtask

    // One product per cycle; a full group is checked on the cycle after its last accept.
    task automatic feed(input int sel, input logic [15:0] q[$]);
        longint unsigned tot = 0;
        foreach (q[i]) begin
            prod_valid = 1'b1;
            prod = q[i];
            sample(sel);
            chk("feed_ready", 64'(s_rdy), 64'd1);
            tot += longint'(q[i]);
            step();
        end
        prod_valid = 1'b0;
        if (q.size() == count_of(sel)) begin
            sample(sel);
            chk("grp_valid", 64'(s_rv), 64'd1);
            chk("grp_ready", 64'(s_rdy), 64'd0);
            chk("grp_res", s_res, 64'(exp_res(sel, tot)));
            chk("grp_ovf", 64'(s_ovf), 64'(exp_ovf(sel, tot)));
        end
    endtask

    // With res_ready high, HOLD lasts one cycle.
    task automatic ack(input int sel);
        res_ready = 1'b1;
        step();
        sample(sel);
        chk("ack_valid", 64'(s_rv), 64'd0);
        chk("ack_ready", 64'(s_rdy), 64'd1);
    endtask

    function automatic void fill(ref logic [15:0] q[$], input int n, input logic [15:0] v);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(v);
    endfunction

    function automatic void fill_rand(ref logic [15:0] q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(16'($urandom_range(0, 16'hFFFF)));
    endfunction

    initial begin
        logic [15:0] q[$];
        logic [63:0] held;
        int          nres;

        // Reset and basic sum
        step();
        do_reset(0);
        fill(q, 8, 16'h0300);
        feed(0, q);
        chk("basic_res", s_res, 64'h1800);
        ack(0);

        // Random groups back-to-back
        for (int g = 0; g < 3; g++) begin
            fill_rand(q, 8);
            feed(0, q);
            ack(0);
        end

        // Backpressure with prod_valid held high in HOLD
        res_ready = 1'b0;
        fill_rand(q, 8);
        feed(0, q);
        held = s_res;
        prod_valid = 1'b1;
        prod = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            sample(0);
            chk("bp_ready", 64'(s_rdy), 64'd0);
            chk("bp_valid", 64'(s_rv), 64'd1);
            chk("bp_res", s_res, held);
        end
        res_ready = 1'b1;
        step();
        sample(0);
        chk("bp_release_ready", 64'(s_rdy), 64'd1);
        chk("bp_release_valid", 64'(s_rv), 64'd0);
        fill_rand(q, 7);
        q.push_front(16'h1234);
        feed(0, q);
        ack(0);

        // Overflow on 16-bit accumulator
        do_reset(1);
        fill(q, 8, 16'hFFFF);
        feed(1, q);
`ifdef ACC_SATURATE_EN
        chk("ovf_res_sat", s_res, 64'hFFFF);
`else
        chk("ovf_res_wrap", s_res, 64'hFFF8);
`endif
        chk("ovf_flag", 64'(s_ovf), 64'd1);
        ack(1);
        fill(q, 8, 16'h0001);
        feed(1, q);
        chk("ovf_next_res", s_res, 64'h0008);
        chk("ovf_next_flag", 64'(s_ovf), 64'd0);
        ack(1);
        for (int g = 0; g < 3; g++) begin
            fill_rand(q, 8);
            feed(1, q);
            ack(1);
        end

        // Mid-group clear
        do_reset(0);
        fill(q, 3, 16'h0010);
        feed(0, q);
        prod_valid = 1'b1;
        prod = 16'h0010;
        clear = 1'b1;
        step();
        clear = 1'b0;
        prod_valid = 1'b0;
        sample(0);
        chk("clr_valid", 64'(s_rv), 64'd0);
        chk("clr_ready", 64'(s_rdy), 64'd1);
        fill(q, 8, 16'h0001);
        feed(0, q);
        chk("clr_res", s_res, 64'h0008);
        ack(0);

        // Clear drops a pending result in HOLD
        res_ready = 1'b0;
        fill_rand(q, 8);
        feed(0, q);
        clear = 1'b1;
        step();
        clear = 1'b0;
        sample(0);
        chk("clr_hold_valid", 64'(s_rv), 64'd0);
        chk("clr_hold_res", s_res, 64'd0);
        res_ready = 1'b1;

        // Reset in HOLD
        res_ready = 1'b0;
        fill(q, 8, 16'h0300);
        feed(0, q);
        do_reset(0);
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            sample(0);
            chk("rst_no_stale", 64'(s_rv), 64'd0);
        end

        // COUNT=1 with prod_valid toggling every other cycle
        do_reset(2);
        nres = 0;
        for (int i = 0; i < 6; i++) begin
            prod_valid = 1'b1;
            prod = (i < 3) ? 16'hABCD : 16'($urandom_range(0, 16'hFFFF));
            held = 64'(prod);
            sample(2);
            chk("gap_ready", 64'(s_rdy), 64'd1);
            step();
            prod_valid = 1'b0;
            sample(2);
            if (s_rv) nres++;
            chk("gap_res", s_res, held);
            chk("gap_ovf", 64'(s_ovf), 64'd0);
            step();
            sample(2);
            if (s_rv) nres++;
        end
        chk("gap_count", 64'(nres), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the 8-bit shift-add multiplier's 16-bit product. Accepts a stream of unsigned products over a valid/ready handshake and sums COUNT consecutive products into a wide accumulator. Presents each completed sum as a registered result with its own valid/ready handshake. Used for dot-product and MAC-style computations built on the multiplier.

## Interface
- ACC_W, 24: accumulator and result width in bits; legal range 16..32.
- COUNT, 8: number of products summed per result; legal range 1..255.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- clear  input  1  synchronous abort: discards the partial sum and any pending result.
- prod_valid  input  1  a product is presented on prod.
- prod_ready  output  1  the block accepts a product this cycle.
- prod  input  16  unsigned product from the multiplier.
- res_valid  output  1  a completed sum is held on res.
- res_ready  input  1  the downstream consumer takes res this cycle.
- res  output  ACC_W  completed sum.
- res_ovf  output  1  sticky overflow flag for the sum currently on res.

## Operation
- The block has two states: ACCUM and HOLD.
- **ACCUM:**
  - prod_ready=1, res_valid=0.
  - An accepted product (prod_valid & prod_ready) does: acc <= acc + zero-extended prod; cnt <= cnt+1; ovf <= ovf | carry out of bit ACC_W-1.
  - On the accept that makes cnt reach COUNT: res <= the final sum, res_ovf <= the final ovf, and the state moves to HOLD.
  - In the same cycle, acc, cnt and ovf are zeroed.
- **HOLD:**
  - prod_ready=0, res_valid=1.
  - res and res_ovf stay stable until res_valid & res_ready.
  - On that handshake the state returns to ACCUM.
- Arithmetic is unsigned, with no sign extension of prod.
- The width of cnt is just enough to hold COUNT.
- **Overflow:**
  - Without the configuration macro, the sum wraps modulo 2^ACC_W.
  - ovf is set on any carry out of bit ACC_W-1 and is never cleared during accumulation of the current group.
- **clear:**
  - Has priority over every other input except rst_n.
  - When asserted, the next state is ACCUM with acc=0, cnt=0, ovf=0, res_valid=0 and res=0.
  - A product presented in the same cycle is not accumulated, even though prod_ready may be 1.
  - A pending result in HOLD is dropped.
- **Reset:** rst_n=0 at a rising edge produces the same state as clear, including mid-group and in HOLD.
  - Reset values: prod_ready=1 (from the cycle after reset onward), res_valid=0, res=0, res_ovf=0.
  - While rst_n is low, prod_ready is driven 0.
- prod_valid=1 in HOLD is ignored. The upstream must hold its product until prod_ready returns.

## Timing
- Accumulation latency is 1 cycle per product. Throughput is 1 product per cycle in ACCUM.
- res_valid rises on the clock edge that accepts the COUNT-th product. It is visible in the cycle immediately after that handshake.
- The minimum period between groups is COUNT+1 cycles: COUNT accept cycles plus 1 HOLD cycle, when res_ready is held high.
- With res_ready held at 1, HOLD lasts exactly one cycle, and prod_ready is 0 in that cycle.
- prod_ready depends only on state and rst_n. It has no combinational path from prod_valid, res_ready or clear.
- res and res_ovf are registered. They change only on entry to HOLD, on clear, or on reset.
- COUNT=1: every accepted product goes directly to HOLD; res equals the zero-extended prod.

## Configuration
- Macro: ACC_SATURATE_EN.
- **Defined:**
  - On any add that would carry out, acc is set to all ones (2^ACC_W-1).
  - The group's later adds keep acc at all ones.
  - ovf/res_ovf are still set.
  - res for the group is 2^ACC_W-1.
- **Undefined:** wrap-around as described in Operation, with ovf/res_ovf still set.
- The handshake, timing and counts are identical in both builds.

## Test plan
- **Basic sum:**
  - Stimulus: COUNT=8, ACC_W=24, eight back-to-back products of 0x0300.
  - Required response: res_valid in the cycle after the 8th accept; res=0x001800; res_ovf=0; prod_ready=0 for exactly one cycle with res_ready=1.
- **Backpressure:**
  - Stimulus: hold res_ready=0 for 5 cycles after a group completes, with prod_valid held high.
  - Required response: res stable and prod_ready=0 throughout; no product accepted until the cycle after the res handshake; the next group sums from 0.
- **Overflow:**
  - Stimulus: ACC_W=16, COUNT=8, eight products of 0xFFFF.
  - Required response without the macro: res=0xFFF8, res_ovf=1.
  - Required response with ACC_SATURATE_EN: res=0xFFFF, res_ovf=1.
  - Following group of eight 0x0001: res=0x0008, res_ovf=0.
- **Mid-group clear:**
  - Stimulus: accept three products of 0x0010, then assert clear in the same cycle as a 4th product, then feed eight products of 0x0001.
  - Required response: the 4th product is not counted; res=0x000008.
- **Reset in HOLD:**
  - Stimulus: complete a group, then pull rst_n low for 1 cycle before res_ready.
  - Required response: res_valid=0, res=0, res_ovf=0; prod_ready=1 the cycle after rst_n rises; no stale result is delivered.
- **Gapped input:**
  - Stimulus: COUNT=1, ACC_W=24, product 0xABCD delivered with prod_valid toggling every other cycle.
  - Required response: res=0x00ABCD for each accepted product; one result per product.
